// File: rtl/llc_lookup_ctrl_pkg.sv
// Shared LLC lookup types and constants: tag/set/way widths, FSM state enum,
// and the eviction-pointer wrap helper.
package llc_lookup_ctrl_pkg;

  localparam int LLC_TAG_BITS = 16;
  localparam int LLC_SET_BITS = 8;
  localparam int LLC_WAYS     = 8;
  localparam int LLC_WAY_BITS = $clog2(LLC_WAYS);

  typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
  typedef logic [LLC_SET_BITS-1:0] llc_set_t;
  typedef logic [LLC_WAY_BITS-1:0] llc_way_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    LOOK,
    RESP
  } llc_lookup_ctrl_state_t;

  // Next eviction way, wrapping LLC_WAYS-1 back to 0 (correct even if LLC_WAYS
  // is not a power of two).
  function automatic llc_way_t llc_next_way(input llc_way_t w);
    return (w == llc_way_t'(LLC_WAYS - 1)) ? '0 : w + llc_way_t'(1);
  endfunction

endpackage

// File: rtl/llc_lookup_ctrl_arbiter.sv
// Round-robin arbiter over N_REQ requesters. The search starts at the
// requester after the last winner; the start pointer only moves on advance_i,
// so an unaccepted grant does not rotate priority. Requester 0 is highest
// priority out of reset.
module llc_rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] start_q, start_d;

  // Pick the first valid requester at or after start_q; scanning from the far
  // end lets the nearest match overwrite any later one without a break.
  always_comb begin : p_pick
    int idx;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = (int'(start_q) + off) % N_REQ;
      if (req_i[IDX_W'(idx)]) begin
        grant_o                 = '0;
        grant_o[IDX_W'(idx)]    = 1'b1;
        grant_idx_o             = IDX_W'(idx);
        any_o                   = 1'b1;
      end
    end
  end

  // Next search start is one past the accepted winner.
  always_comb begin
    start_d = start_q;
    if (advance_i && any_o) begin
      start_d = (grant_idx_o == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    end
  end

  // Search-start pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= '0;
    else     start_q <= start_d;
  end

endmodule

// File: rtl/llc_lookup_ctrl.sv
// LLC way-lookup arbiter/sequencer. Grants one requester, reads the set's
// tag/state RAM, strobes the way-lookup block, returns way/evict on a
// valid/ready port and owns the round-robin eviction pointer.
// Optional feature macro: LLC_LOOKUP_STATS_EN adds stat_lookups/stat_evicts.
module llc_lookup_ctrl
  import llc_lookup_ctrl_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int RD_LAT = 1,
  localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  llc_tag_t         req_tag [N_REQ],
  input  llc_set_t         req_set [N_REQ],
  output logic             rd_en,
  output llc_set_t         rd_set,
  output logic             lookup_en,
  output llc_tag_t         lookup_tag,
  output llc_way_t         evict_way_buf,
  input  llc_way_t         lk_way,
  input  logic             lk_evict,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [SRC_W-1:0] resp_src,
  output llc_set_t         resp_set,
  output llc_way_t         resp_way,
`ifdef LLC_LOOKUP_STATS_EN
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_evicts,
`endif
  output logic             resp_evict
);

  localparam int CNT_W = 3;

  llc_lookup_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  llc_tag_t               tag_q, tag_d;
  llc_set_t               set_q, set_d;
  logic [SRC_W-1:0]       src_q, src_d;
  llc_way_t               evict_q, evict_d;

  logic [N_REQ-1:0]       arb_grant;
  logic [SRC_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   arb_advance;
  logic                   resp_hs;

  // Only IDLE accepts requests, so priority rotates only on a real grant.
  assign arb_advance = (state_q == IDLE) && arb_any;
  assign resp_hs     = (state_q == RESP) && resp_ready;

  llc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid),
    .advance_i   (arb_advance),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  // Latched request fields drive the RAM address, lookup tag and response
  // metadata directly, so they hold from grant until the response handshake.
  assign rd_set        = set_q;
  assign lookup_tag    = tag_q;
  assign resp_src      = src_q;
  assign resp_set      = set_q;
  assign evict_way_buf = evict_q;

  // Next-state and strobe/output decode for the lookup sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    set_d      = set_q;
    src_d      = src_q;
    evict_d    = evict_q;
    req_ready  = '0;
    rd_en      = 1'b0;
    lookup_en  = 1'b0;
    resp_valid = 1'b0;
    resp_way   = '0;
    resp_evict = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          tag_d     = req_tag[arb_idx];
          set_d     = req_set[arb_idx];
          src_d     = arb_idx;
          state_d   = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (RD_LAT <= 1) begin
          state_d = LOOK;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Leave when the decremented count reaches zero.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = LOOK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOOK: begin
        lookup_en = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        // Way-lookup result is registered on its side and held, so pass it live.
        resp_valid = 1'b1;
        resp_way   = lk_way;
        resp_evict = lk_evict;
        if (resp_ready) begin
          state_d = IDLE;
          if (lk_evict) evict_d = llc_next_way(evict_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, latched request and eviction pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      set_q   <= '0;
      src_q   <= '0;
      evict_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      src_q   <= src_d;
      evict_q <= evict_d;
    end
  end

`ifdef LLC_LOOKUP_STATS_EN
  logic [31:0] stat_lookups_q, stat_evicts_q;

  assign stat_lookups = stat_lookups_q;
  assign stat_evicts  = stat_evicts_q;

  // Saturating lookup/evict counters, stepped on each response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_evicts_q  <= '0;
    end else if (resp_hs) begin
      if (stat_lookups_q != '1) stat_lookups_q <= stat_lookups_q + 32'd1;
      if (lk_evict && (stat_evicts_q != '1)) stat_evicts_q <= stat_evicts_q + 32'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = resp_hs;
`endif

endmodule
